// File: rtl/axi3_burst_addr_gen.sv
// axi3_burst_addr_gen: per-beat AXI3/AXI4 burst address, strobe, index and last generator.
// Define AXI3_4K_CHECK_EN to add the beat_4k_err output and flag INCR bursts crossing a 4 KB page.
module axi3_burst_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_W-1:0]     beat_addr,
  output logic [DATA_BYTES-1:0] beat_strb,
  output logic                  beat_last,
  output logic [LEN_W-1:0]      beat_idx,
  output logic                  cmd_err
`ifdef AXI3_4K_CHECK_EN
  ,
  output logic                  beat_4k_err
`endif
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));
  localparam int         OFF_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d, wmask_q;
  logic [LEN_W-1:0]  len_q, idx_q, idx_d;
  logic [2:0]        size_q;
  logic [1:0]        mode_q;
  logic              err_q;
  logic              cmd_fire, beat_fire;

  logic [2:0]        c_size;
  logic [1:0]        c_mode;
  logic              c_err, c_wrap_len_ok;
  logic [ADDR_W-1:0] c_bmask, c_wmask;
  logic [ADDR_W-1:0] bmask, incr;
  int                lo, hi;
`ifdef AXI3_4K_CHECK_EN
  logic [ADDR_W-1:0] c_end, page_q;
`endif

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = beat_valid && beat_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = BUSY;
      BUSY:    if (beat_fire && beat_last) state_d = cmd_fire ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepting a command on the last beat keeps the pipe full with no bubble.
  always_comb begin
    beat_valid = (state_q == BUSY);
    beat_last  = beat_valid && (idx_q == len_q);
    cmd_ready  = (state_q == IDLE) || (beat_valid && beat_ready && beat_last);
  end

  // Command decode: illegal fields are flagged and degraded to a legal burst.
  always_comb begin
    c_err  = 1'b0;
    c_size = cmd_size;
    if (cmd_size > MAX_SIZE) begin
      c_size = MAX_SIZE;
      c_err  = 1'b1;
    end
    c_bmask       = (ADDR_W'(1) << c_size) - ADDR_W'(1);
    c_wrap_len_ok = (cmd_len == LEN_W'(1)) || (cmd_len == LEN_W'(3)) ||
                    (cmd_len == LEN_W'(7)) || (cmd_len == LEN_W'(15));
    c_mode = cmd_burst;
    if (cmd_burst == 2'b11) begin
      c_mode = BT_INCR;
      c_err  = 1'b1;
    end else if (cmd_burst == BT_WRAP &&
                 (!c_wrap_len_ok || (cmd_addr & c_bmask) != '0)) begin
      c_mode = BT_INCR;
      c_err  = 1'b1;
    end
    c_wmask = ((ADDR_W'(cmd_len) + ADDR_W'(1)) << c_size) - ADDR_W'(1);
`ifdef AXI3_4K_CHECK_EN
    c_end = (cmd_addr & ~c_bmask) + (ADDR_W'(cmd_len) << c_size);
    if (c_mode == BT_INCR && ((c_end ^ cmd_addr) >> 12) != '0) c_err = 1'b1;
`endif
  end

  always_comb begin
    bmask  = (ADDR_W'(1) << size_q) - ADDR_W'(1);
    incr   = (addr_q & ~bmask) + bmask + ADDR_W'(1);
    addr_d = addr_q;
    idx_d  = idx_q;
    if (cmd_fire) begin
      addr_d = cmd_addr;
      idx_d  = '0;
    end else if (beat_fire && !beat_last) begin
      idx_d = idx_q + LEN_W'(1);
      case (mode_q)
        BT_FIXED: addr_d = addr_q;
        BT_WRAP:  addr_d = (addr_q & ~wmask_q) | (incr & wmask_q);
        default:  addr_d = incr;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      mode_q  <= BT_INCR;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      err_q  <= cmd_fire && c_err;
      if (cmd_fire) begin
        len_q   <= cmd_len;
        size_q  <= c_size;
        mode_q  <= c_mode;
        wmask_q <= c_wmask;
      end
    end
  end

  // Lanes from the byte offset up to the end of its size-aligned group.
  always_comb begin
    beat_strb = '0;
    lo = int'(addr_q[OFF_W-1:0]) & (DATA_BYTES - 1);
    hi = lo | ((1 << size_q) - 1);
    for (int i = 0; i < DATA_BYTES; i++)
      if (beat_valid && i >= lo && i <= hi) beat_strb[i] = 1'b1;
  end

  assign beat_addr = addr_q;
  assign beat_idx  = idx_q;
  assign cmd_err   = err_q;

`ifdef AXI3_4K_CHECK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      page_q <= '0;
    else if (cmd_fire) page_q <= cmd_addr;
  end

  assign beat_4k_err = beat_valid && (mode_q == BT_INCR) && (((addr_q ^ page_q) >> 12) != '0);
`endif
endmodule
